acumulador_multicanal: RTL and testbench
========================================

# acumulador_multicanal

Multi-channel accumulator: the parametrised successor of the team's single-channel accumulator. Keeps the two-step Load/Transfer flow: an operand register captures memory data, then a commit applies it to one of `CANAIS` independent accumulators. Adds channel addressing, add/subtract/overwrite/clear modes, optional unsigned saturation, sticky per-channel overflow flags and an overwrite-loss indicator. Sits between the memory data bus `M` and the datapath consumers, as the single-channel block did.

## Interface
- `TAMANHO`, 16, data and accumulator width in bits (≥2)
- `CANAIS`, 4, number of accumulator channels (power of two, ≥2); `CL` = $clog2(CANAIS)
- `SATURA`, 0, 0 = modular (wrap) arithmetic, 1 = unsigned saturation
- `Clock`  in  1  single clock; all state changes on rising edge
- `Clear`  in  1  reset, synchronous, active-low; dominates every other input
- `Load`  in  1  capture `M`, `CanalIn`, `Modo` into operand register
- `M`  in  TAMANHO  operand data
- `CanalIn`  in  CL  target channel for the captured operand
- `Modo`  in  2  00 add, 01 subtract, 10 overwrite (A ← B), 11 clear channel
- `Transfer`  in  1  commit pending operand to its channel
- `CanalOut`  in  CL  read-select for `Saidas`
- `Saidas`  out  TAMANHO  accumulator[`CanalOut`], combinational mux of registers
- `Cheio`  out  1  operand register holds an uncommitted operand
- `Overflow`  out  CANAIS  sticky per-channel overflow/underflow flag
- `Descartado`  out  1  one-cycle pulse: a pending operand was overwritten without commit

## Operation
- State: operand register {B data, B channel, B mode}, `Cheio` bit, CANAIS accumulators, CANAIS overflow bits, `Descartado` register.
- Two-state control per operand: VAZIO (`Cheio`=0) and PENDENTE (`Cheio`=1).
  - VAZIO + Load → PENDENTE; Transfer ignored (no accumulator change, no flag).
  - PENDENTE + Transfer, no Load → commit, → VAZIO.
  - PENDENTE + Transfer + Load → commit old operand, capture new, stay PENDENTE, `Descartado`=0.
  - PENDENTE + Load, no Transfer → overwrite operand, stay PENDENTE, `Descartado`=1 next cycle.
- Commit on channel c = B channel:
  - Add: full sum computed in TAMANHO+1 bits; carry out sets `Overflow[c]`. Result = low TAMANHO bits if `SATURA`=0, all-ones on carry if `SATURA`=1.
  - Subtract: A − B; borrow sets `Overflow[c]`. Result wraps if `SATURA`=0, 0 on borrow if `SATURA`=1.
  - Overwrite: A[c] ← B; `Overflow[c]` unchanged.
  - Clear channel: A[c] ← 0 and `Overflow[c]` ← 0; B data ignored.
- `Overflow[c]` is set-only except via clear-channel mode or `Clear`. Other channels never change on a commit to c.
- All arithmetic is unsigned.

## Timing
- `Clear`=0 sampled at an edge → after that edge: all accumulators 0, operand register 0, `Cheio`=0, `Overflow`=0, `Descartado`=0. `Saidas`=0 for every `CanalOut`.
- `Clear` mid-operation discards any pending operand; Load/Transfer in the same cycle have no effect.
- Load sampled at edge k → `Cheio`=1 after k.
- Transfer at edge k+1 → A[c] and `Overflow[c]` updated after k+1; `Cheio`=0 after k+1 unless Load was also asserted.
- Minimum Load-to-`Saidas` latency: 2 edges. Back-to-back Load+Transfer every cycle sustains one commit per cycle.
- `Saidas` follows `CanalOut` combinationally, with zero cycles of latency; the read is never stalled by a commit.
- `Descartado` is high for exactly the one cycle after the overwriting edge, and is otherwise 0.

## Test plan
- Reset then accumulate: `Clear` low 1 cycle; on ch 2 load 0x0005 add + Transfer, then 0x0003 add + Transfer → `Saidas`(CanalOut=2)=0x0008, other channels 0, `Overflow`=0000.
- Wrap vs saturate: ch 1 = 0xFFF0, add 0x0020. With `SATURA`=0 → 0x0010 and `Overflow[1]`=1. With `SATURA`=1 → 0xFFFF and `Overflow[1]`=1. Then subtract 0x0030 from 0x0010 (`SATURA`=1) → 0x0000.
- Handshake corners: Transfer with `Cheio`=0 → no change. Load, Load (no Transfer) → `Descartado` pulses 1 cycle, and a later Transfer commits only the second operand. Load+Transfer held 4 cycles with 0x0001 on ch 0 → ch 0 = 0x0003 after cycle 4, `Cheio`=1.
- Modes: ch 3 overwrite 0x1234 → 0x1234. Subtract 0x0234 → 0x1000. Clear-channel → 0x0000 and `Overflow[3]` cleared. Ch 0–2 unchanged.
- Reset mid-operation: operand pending, `Clear`=0 together with Transfer → accumulators stay 0, `Cheio`=0. A Transfer the next cycle has no effect.
- Channel isolation sweep: write distinct values to all CANAIS channels, then sweep `CanalOut` → each returns its own value the same cycle.

Source files
------------

// File: rtl/acumulador_multicanal.sv
// acumulador_multicanal: CANAIS independent unsigned accumulators fed through
// a single operand register using a two-step Load/Transfer flow.
//
// Handshake: Load captures {M, CanalIn, Modo} into the operand register on any
// edge where Clear is high. Transfer commits the held operand only while an
// operand is pending (Cheio=1); a Transfer with Cheio=0 is ignored. Load and
// Transfer together commit the old operand and capture the new one in the same
// edge. A Load without Transfer while pending replaces the operand and pulses
// Descartado for one cycle.
module acumulador_multicanal #(
  parameter int TAMANHO = 16,
  parameter int CANAIS  = 4,
  parameter int SATURA  = 0
) (
  input  logic                        Clock,
  input  logic                        Clear,
  input  logic                        Load,
  input  logic [TAMANHO-1:0]          M,
  input  logic [$clog2(CANAIS)-1:0]   CanalIn,
  input  logic [1:0]                  Modo,
  input  logic                        Transfer,
  input  logic [$clog2(CANAIS)-1:0]   CanalOut,
  output logic [TAMANHO-1:0]          Saidas,
  output logic                        Cheio,
  output logic [CANAIS-1:0]           Overflow,
  output logic                        Descartado
);

  localparam int CL = $clog2(CANAIS);

  localparam logic [1:0] MODO_SOMA  = 2'b00;
  localparam logic [1:0] MODO_SUB   = 2'b01;
  localparam logic [1:0] MODO_ESCR  = 2'b10;
  localparam logic [1:0] MODO_LIMPA = 2'b11;

  typedef enum logic {VAZIO = 1'b0, PENDENTE = 1'b1} estado_t;

  estado_t              r_estado;
  logic [TAMANHO-1:0]   r_b_dado;
  logic [CL-1:0]        r_b_canal;
  logic [1:0]           r_b_modo;
  logic [TAMANHO-1:0]   r_acc [CANAIS];
  logic [CANAIS-1:0]    r_ovf;
  logic                 r_descartado;

  logic                 w_commit;
  logic [TAMANHO-1:0]   w_a;
  logic [TAMANHO:0]     w_soma;
  logic [TAMANHO:0]     w_dif;
  logic [TAMANHO-1:0]   w_res;
  logic                 w_ovf_set;
  logic                 w_ovf_clr;

  assign w_commit = (r_estado == PENDENTE) && Transfer;

  // Result and flag update for the channel addressed by the pending operand
  always_comb begin
    w_a       = r_acc[r_b_canal];
    w_soma    = {1'b0, w_a} + {1'b0, r_b_dado};
    w_dif     = {1'b0, w_a} - {1'b0, r_b_dado};
    w_res     = w_a;
    w_ovf_set = 1'b0;
    w_ovf_clr = 1'b0;
    case (r_b_modo)
      MODO_SOMA: begin
        w_ovf_set = w_soma[TAMANHO];
        w_res     = ((SATURA != 0) && w_soma[TAMANHO]) ? {TAMANHO{1'b1}}
                                                       : w_soma[TAMANHO-1:0];
      end
      MODO_SUB: begin
        // The extra top bit of the difference is the borrow out
        w_ovf_set = w_dif[TAMANHO];
        w_res     = ((SATURA != 0) && w_dif[TAMANHO]) ? {TAMANHO{1'b0}}
                                                      : w_dif[TAMANHO-1:0];
      end
      MODO_ESCR: begin
        w_res = r_b_dado;
      end
      MODO_LIMPA: begin
        w_res     = '0;
        w_ovf_clr = 1'b1;
      end
      default: begin
        w_res = w_a;
      end
    endcase
  end

  // Control FSM, operand register, accumulators and flags
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      r_estado     <= VAZIO;
      r_b_dado     <= '0;
      r_b_canal    <= '0;
      r_b_modo     <= '0;
      r_ovf        <= '0;
      r_descartado <= 1'b0;
      for (int i = 0; i < CANAIS; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_descartado <= 1'b0;

      if (w_commit) begin
        r_acc[r_b_canal] <= w_res;
        if (w_ovf_clr) begin
          r_ovf[r_b_canal] <= 1'b0;
        end else if (w_ovf_set) begin
          r_ovf[r_b_canal] <= 1'b1;
        end
      end

      // Load always captures; the commit above has already used the old operand
      if (Load) begin
        r_b_dado  <= M;
        r_b_canal <= CanalIn;
        r_b_modo  <= Modo;
      end

      case (r_estado)
        VAZIO: begin
          if (Load) begin
            r_estado <= PENDENTE;
          end
        end
        PENDENTE: begin
          if (Load) begin
            r_descartado <= !Transfer;
          end else if (Transfer) begin
            r_estado <= VAZIO;
          end
        end
        default: begin
          r_estado <= VAZIO;
        end
      endcase
    end
  end

  assign Saidas     = r_acc[CanalOut];
  assign Cheio      = (r_estado == PENDENTE);
  assign Overflow   = r_ovf;
  assign Descartado = r_descartado;

endmodule

// File: tb/tb_acumulador_multicanal.sv
// Directed bench for acumulador_multicanal. Two instances share all inputs:
// one with wrap arithmetic and one with unsigned saturation.
module tb_acumulador_multicanal;

  logic        clk;
  logic        clear;
  logic        load;
  logic [15:0] m;
  logic [1:0]  canal_in;
  logic [1:0]  modo;
  logic        transfer;
  logic [1:0]  canal_out;

  logic [15:0] saidas_w, saidas_s;
  logic        cheio_w, cheio_s;
  logic [3:0]  ovf_w, ovf_s;
  logic        desc_w, desc_s;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] SOMA  = 2'b00;
  localparam logic [1:0] SUB   = 2'b01;
  localparam logic [1:0] ESCR  = 2'b10;
  localparam logic [1:0] LIMPA = 2'b11;

  acumulador_multicanal #(.TAMANHO(16), .CANAIS(4), .SATURA(0)) u_wrap (
    .Clock(clk), .Clear(clear), .Load(load), .M(m), .CanalIn(canal_in),
    .Modo(modo), .Transfer(transfer), .CanalOut(canal_out),
    .Saidas(saidas_w), .Cheio(cheio_w), .Overflow(ovf_w), .Descartado(desc_w)
  );

  acumulador_multicanal #(.TAMANHO(16), .CANAIS(4), .SATURA(1)) u_sat (
    .Clock(clk), .Clear(clear), .Load(load), .M(m), .CanalIn(canal_in),
    .Modo(modo), .Transfer(transfer), .CanalOut(canal_out),
    .Saidas(saidas_s), .Cheio(cheio_s), .Overflow(ovf_s), .Descartado(desc_s)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read one channel from both instances in the same cycle
  task automatic rd(input logic [1:0] c, input logic [15:0] exp_w, input logic [15:0] exp_s);
    canal_out = c;
    #1;
    chk($sformatf("wrap ch%0d", c), saidas_w, exp_w);
    chk($sformatf("sat ch%0d", c), saidas_s, exp_s);
  endtask

  task automatic flags(input string tag, input logic cheio_e, input logic [3:0] ovf_w_e,
                       input logic [3:0] ovf_s_e, input logic desc_e);
    chk({tag, " wrap cheio"}, {15'd0, cheio_w}, {15'd0, cheio_e});
    chk({tag, " sat cheio"},  {15'd0, cheio_s}, {15'd0, cheio_e});
    chk({tag, " wrap ovf"},   {12'd0, ovf_w},   {12'd0, ovf_w_e});
    chk({tag, " sat ovf"},    {12'd0, ovf_s},   {12'd0, ovf_s_e});
    chk({tag, " wrap desc"},  {15'd0, desc_w},  {15'd0, desc_e});
    chk({tag, " sat desc"},   {15'd0, desc_s},  {15'd0, desc_e});
  endtask

  // Load one operand, then commit it on the following edge
  task automatic op(input logic [1:0] c, input logic [1:0] md, input logic [15:0] d);
    load = 1'b1; m = d; canal_in = c; modo = md;
    tick();
    load = 1'b0;
    transfer = 1'b1;
    tick();
    transfer = 1'b0;
  endtask

  initial begin
    clear = 1'b0; load = 1'b0; m = '0; canal_in = '0; modo = '0;
    transfer = 1'b0; canal_out = '0;

    // Reset state
    tick();
    tick();
    flags("reset", 1'b0, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) rd(i[1:0], 16'h0000, 16'h0000);
    clear = 1'b1;

    // Accumulate on ch 2, with a latency check after the Load edge
    load = 1'b1; m = 16'h0005; canal_in = 2'd2; modo = SOMA;
    tick();
    load = 1'b0;
    rd(2'd2, 16'h0000, 16'h0000);
    flags("after load", 1'b1, 4'b0000, 4'b0000, 1'b0);
    transfer = 1'b1;
    tick();
    transfer = 1'b0;
    rd(2'd2, 16'h0005, 16'h0005);
    flags("after commit", 1'b0, 4'b0000, 4'b0000, 1'b0);
    op(2'd2, SOMA, 16'h0003);
    rd(2'd2, 16'h0008, 16'h0008);
    rd(2'd0, 16'h0000, 16'h0000);
    rd(2'd1, 16'h0000, 16'h0000);
    rd(2'd3, 16'h0000, 16'h0000);

    // Wrap vs saturate on ch 1
    op(2'd1, ESCR, 16'hFFF0);
    op(2'd1, SOMA, 16'h0020);
    rd(2'd1, 16'h0010, 16'hFFFF);
    flags("add carry", 1'b0, 4'b0010, 4'b0010, 1'b0);
    op(2'd1, ESCR, 16'h0010);
    op(2'd1, SUB, 16'h0030);
    rd(2'd1, 16'hFFE0, 16'h0000);
    flags("sub borrow", 1'b0, 4'b0010, 4'b0010, 1'b0);

    // Transfer while empty is ignored
    transfer = 1'b1;
    tick();
    transfer = 1'b0;
    rd(2'd2, 16'h0008, 16'h0008);
    flags("idle transfer", 1'b0, 4'b0010, 4'b0010, 1'b0);

    // Load, Load: first operand discarded, Descartado pulses one cycle
    load = 1'b1; m = 16'h0100; canal_in = 2'd2; modo = SOMA;
    tick();
    m = 16'h0200;
    tick();
    load = 1'b0;
    flags("second load", 1'b1, 4'b0010, 4'b0010, 1'b1);
    tick();
    flags("pulse end", 1'b1, 4'b0010, 4'b0010, 1'b0);
    rd(2'd2, 16'h0008, 16'h0008);
    transfer = 1'b1;
    tick();
    transfer = 1'b0;
    rd(2'd2, 16'h0208, 16'h0208);
    flags("late commit", 1'b0, 4'b0010, 4'b0010, 1'b0);

    // Load+Transfer held four cycles with 1 on ch 0
    load = 1'b1; transfer = 1'b1; m = 16'h0001; canal_in = 2'd0; modo = SOMA;
    for (int k = 0; k < 4; k++) tick();
    load = 1'b0; transfer = 1'b0;
    rd(2'd0, 16'h0003, 16'h0003);
    flags("streaming", 1'b1, 4'b0010, 4'b0010, 1'b0);
    transfer = 1'b1;
    tick();
    transfer = 1'b0;
    rd(2'd0, 16'h0004, 16'h0004);

    // Modes on ch 3
    op(2'd3, ESCR, 16'h1234);
    rd(2'd3, 16'h1234, 16'h1234);
    op(2'd3, SUB, 16'h0234);
    rd(2'd3, 16'h1000, 16'h1000);
    op(2'd3, SUB, 16'h2000);
    rd(2'd3, 16'hF000, 16'h0000);
    flags("ch3 borrow", 1'b0, 4'b1010, 4'b1010, 1'b0);
    op(2'd3, LIMPA, 16'hABCD);
    rd(2'd3, 16'h0000, 16'h0000);
    flags("ch3 clear", 1'b0, 4'b0010, 4'b0010, 1'b0);
    rd(2'd0, 16'h0004, 16'h0004);
    rd(2'd1, 16'hFFE0, 16'h0000);
    rd(2'd2, 16'h0208, 16'h0208);

    // Clear while an operand is pending, together with Load and Transfer
    load = 1'b1; m = 16'h5555; canal_in = 2'd2; modo = ESCR;
    tick();
    clear = 1'b0; transfer = 1'b1;
    tick();
    clear = 1'b1; load = 1'b0;
    flags("mid reset", 1'b0, 4'b0000, 4'b0000, 1'b0);
    rd(2'd2, 16'h0000, 16'h0000);
    rd(2'd0, 16'h0000, 16'h0000);
    tick();
    transfer = 1'b0;
    rd(2'd2, 16'h0000, 16'h0000);
    flags("post reset", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Channel isolation sweep
    op(2'd0, ESCR, 16'hA0A0);
    op(2'd1, ESCR, 16'hB1B1);
    op(2'd2, ESCR, 16'hC2C2);
    op(2'd3, ESCR, 16'hD3D3);
    rd(2'd0, 16'hA0A0, 16'hA0A0);
    rd(2'd1, 16'hB1B1, 16'hB1B1);
    rd(2'd2, 16'hC2C2, 16'hC2C2);
    rd(2'd3, 16'hD3D3, 16'hD3D3);
    rd(2'd1, 16'hB1B1, 16'hB1B1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
